// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: holds the PC, fetches one 32-bit instruction per retired
// instruction over an AXI-lite read channel and announces it with a one-cycle pulse.
module ifu_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  pc_update,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  fetch_err,
    output logic                  busy,
    output logic [31:0]           araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [63:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IF_BOOT,
        IF_AR,
        IF_R,
        IF_DONE,
        IF_WAIT
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_inst;
    logic                  r_fetch_err;
    logic                  r_inst_valid;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_busy;

    logic                  w_pc_aligned;
    logic                  w_next_aligned;
    logic [31:0]           w_word;

    assign w_pc_aligned   = (r_pc[1:0] == 2'b00);
    assign w_next_aligned = (pc_next[1:0] == 2'b00);
    // 64-bit beat carries two instructions; pc[2] picks the half.
    assign w_word         = r_pc[2] ? rdata[63:32] : rdata[31:0];

    // Handshake outputs are set together with the state they belong to, so they are
    // pure functions of registered state and never combinational from AXI inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IF_BOOT;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_fetch_err  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_inst_valid <= 1'b0;
            unique case (r_state)
                IF_BOOT: begin
                    r_state   <= IF_AR;
                    r_arvalid <= w_pc_aligned;
                end
                IF_AR: begin
                    if (!w_pc_aligned) begin
                        r_inst       <= 32'h0;
                        r_fetch_err  <= 1'b1;
                        r_inst_valid <= 1'b1;
                        r_arvalid    <= 1'b0;
                        r_state      <= IF_DONE;
                    end else if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= IF_R;
                    end
                end
                IF_R: begin
                    if (rvalid) begin
                        r_inst       <= w_word;
                        r_fetch_err  <= (rresp != 2'b00);
                        r_inst_valid <= 1'b1;
                        r_rready     <= 1'b0;
                        r_state      <= IF_DONE;
                    end
                end
                IF_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IF_WAIT;
                end
                IF_WAIT: begin
                    if (pc_update) begin
                        r_pc      <= pc_next;
                        r_arvalid <= w_next_aligned;
                        r_busy    <= 1'b1;
                        r_state   <= IF_AR;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= IF_BOOT;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;
    assign busy       = r_busy;
    assign araddr     = r_pc[31:0];
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written corner
// sequences and randomized fetches checked against a transaction-level model.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_next;
    logic        pc_update;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic        busy;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_chk  = 0;
    int n_pass = 0;

    ifu_fetch #(.ADDR_WIDTH(64), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .pc_update(pc_update),
        .pc(pc), .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err),
        .busy(busy), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pcn;
        int          aw;
        int          rw;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [31:0] e_inst;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Transaction-level reference: what one fetch of pcn must produce.
    task automatic ref_model(input logic [63:0] pcn, input int aw, input int rw,
                             input logic [63:0] data, input logic [1:0] resp,
                             output logic [31:0] e_inst, output logic e_err, output int e_lat);
        bit mis;
        mis = (pcn % 4) != 0;
        if (mis) begin
            e_inst = 32'h0;
            e_err  = 1'b1;
            e_lat  = 2;
        end else begin
            e_inst = ((pcn / 4) % 2 == 1) ? data[63:32] : data[31:0];
            e_err  = (resp != 2'b00);
            e_lat  = 3 + aw + rw;
        end
    endtask

    task automatic quiet();
        pc_update = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
    endtask

    // One fetch: optional accepted pc_update, then a slave with aw/rw wait cycles.
    // Cycle t counts from the accepting edge; outputs are sampled 1 time unit after edges.
    task automatic fetch(input string nm, input bit upd, input logic [63:0] pcn,
                         input int aw, input int rw, input logic [63:0] data,
                         input logic [1:0] resp, input logic [31:0] e_inst,
                         input logic e_err, input int e_lat, input bit ign);
        int t, ar_cnt, r_cnt, ar_bad, lat, e_ar;
        bit done;
        t = 1; ar_cnt = 0; r_cnt = 0; ar_bad = 0; lat = -1; done = 1'b0;
        e_ar = ((pcn % 4) != 0) ? 0 : aw + 1;
        if (upd) begin
            pc_next   = pcn;
            pc_update = 1'b1;
        end
        @(posedge clk); #1;
        pc_update = 1'b0;
        while (!done && t <= 64) begin
            pc_update = 1'b0;
            if (inst_valid) begin
                done = 1'b1;
                lat  = t;
            end else begin
                if (arvalid) begin
                    if (araddr !== pcn[31:0]) ar_bad++;
                    ar_cnt++;
                end
                arready = arvalid ? (ar_cnt == aw + 1) : 1'($urandom_range(1));
                if (rready) r_cnt++;
                rvalid = rready ? (r_cnt == rw + 1) : 1'($urandom_range(1));
                rdata  = rready ? data : {32'($urandom), 32'($urandom)};
                rresp  = rready ? resp : 2'($urandom);
                if (ign && rready && r_cnt == 1) begin
                    pc_update = 1'b1;
                    pc_next   = 64'hDEAD;
                end
                @(posedge clk); #1;
                t++;
            end
        end
        quiet();
        check({nm, " latency"}, 64'(lat), 64'(e_lat));
        check({nm, " inst"}, 64'(inst), 64'(e_inst));
        check({nm, " fetch_err"}, 64'(fetch_err), 64'(e_err));
        check({nm, " pc"}, pc, pcn);
        check({nm, " ar cycles"}, 64'(ar_cnt), 64'(e_ar));
        check({nm, " araddr stable"}, 64'(ar_bad), 64'd0);
        @(posedge clk); #1;
        check({nm, " pulse width"}, 64'(inst_valid), 64'd0);
        check({nm, " busy low"}, 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({nm, " inst held"}, 64'(inst), 64'(e_inst));
        check({nm, " err held"}, 64'(fetch_err), 64'(e_err));
        if (ign) begin
            check({nm, " still waiting"}, 64'(busy), 64'd0);
            check({nm, " pc kept"}, pc, pcn);
        end
    endtask

    initial begin
        logic [63:0] r_pcn, r_data;
        logic [1:0]  r_resp;
        logic [31:0] m_inst;
        logic        m_err;
        int          m_lat, r_aw, r_rw;

        vecs[0] = '{64'h8000_0004, 3, 2, 64'h0010_0093_DEAD_BEEF, 2'b00, 32'h0010_0093, 1'b0, 8};
        vecs[1] = '{64'h8000_0008, 0, 0, 64'h0000_0000_0000_1234, 2'b10, 32'h0000_1234, 1'b1, 3};
        vecs[2] = '{64'h8000_000C, 1, 0, 64'hAAAA_5555_0000_1111, 2'b00, 32'hAAAA_5555, 1'b0, 4};
        vecs[3] = '{64'h8000_0006, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 32'h0000_0000, 1'b1, 2};
        vecs[4] = '{64'h0000_0001_2345_6780, 0, 3, 64'h0000_00FF_1111_2222, 2'b11, 32'h1111_2222, 1'b1, 6};
        vecs[5] = '{64'h8000_0001, 2, 1, 64'h5555_6666_7777_8888, 2'b00, 32'h0000_0000, 1'b1, 2};

        rst = 1'b1; pc_next = 64'h0; rdata = 64'h0; rresp = 2'b00;
        quiet();
        repeat (3) @(posedge clk);
        #1;
        check("reset pc", pc, RST_PC);
        check("reset inst", 64'(inst), 64'd0);
        check("reset fetch_err", 64'(fetch_err), 64'd0);
        check("reset inst_valid", 64'(inst_valid), 64'd0);
        check("reset arvalid", 64'(arvalid), 64'd0);
        check("reset rready", 64'(rready), 64'd0);
        check("reset busy", 64'(busy), 64'd1);

        rst = 1'b0;
        fetch("boot", 1'b0, RST_PC, 0, 0, 64'hFFFF_FFFF_0000_0413, 2'b00,
              32'h0000_0413, 1'b0, 3, 1'b0);

        for (int i = 0; i < 6; i++)
            fetch($sformatf("vec%0d", i), 1'b1, vecs[i].pcn, vecs[i].aw, vecs[i].rw,
                  vecs[i].data, vecs[i].resp, vecs[i].e_inst, vecs[i].e_err, vecs[i].e_lat, 1'b0);

        fetch("ignored update", 1'b1, 64'h8000_0010, 0, 2, 64'h0BAD_F00D_CAFE_0001, 2'b00,
              32'hCAFE_0001, 1'b0, 5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r_pcn = {32'($urandom), 32'($urandom)};
            if ($urandom_range(3) != 0) r_pcn[1:0] = 2'b00;
            r_aw   = int'($urandom_range(3));
            r_rw   = int'($urandom_range(3));
            r_data = {32'($urandom), 32'($urandom)};
            r_resp = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            ref_model(r_pcn, r_aw, r_rw, r_data, r_resp, m_inst, m_err, m_lat);
            fetch($sformatf("rand%0d", i), 1'b1, r_pcn, r_aw, r_rw, r_data, r_resp,
                  m_inst, m_err, m_lat, 1'b0);
        end

        // Reset while waiting for read data.
        pc_next = 64'h8000_0020; pc_update = 1'b1;
        @(posedge clk); #1;
        pc_update = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        check("mid rready before reset", 64'(rready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid reset rready", 64'(rready), 64'd0);
        check("mid reset arvalid", 64'(arvalid), 64'd0);
        check("mid reset pc", pc, RST_PC);
        check("mid reset inst", 64'(inst), 64'd0);
        check("mid reset busy", 64'(busy), 64'd1);
        rst = 1'b0;
        fetch("reboot", 1'b0, RST_PC, 1, 1, 64'h0000_0001_0000_0073, 2'b00,
              32'h0000_0073, 1'b0, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
